// File: rtl/rv32_pipeline_pkg.sv
// Shared decode-stage types: immediate format selects and elastic-buffer states.
// Optional macro IMM_RVC_EN adds the compressed formats CI, CB and CJ.
package rv32_pipeline_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned SEL_W   = 4;

  // Immediate format select; codes not listed here decode as illegal.
  typedef enum logic [SEL_W-1:0] {
    I_TYPE  = 4'd0,
    S_TYPE  = 4'd1,
    B_TYPE  = 4'd2,
    U_TYPE  = 4'd3,
    J_TYPE  = 4'd4,
    Z_TYPE  = 4'd5
`ifdef IMM_RVC_EN
    ,
    CI_TYPE = 4'd6,
    CB_TYPE = 4'd7,
    CJ_TYPE = 4'd8
`endif
  } IMMEDIATE_SELECT;

  // Occupancy of the two-entry elastic buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for one instruction word.
// Ports: instr_i   raw instruction (compressed forms in [15:0])
//        sel_i     immediate format select
//        imm_c_o   XLEN-wide extended immediate (0 when illegal)
//        illegal_c_o  sel_i is not a supported format
// Macro IMM_RVC_EN enables the CI/CB/CJ compressed formats.
module imm_decode
  import rv32_pipeline_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  IMMEDIATE_SELECT    sel_i,
  output logic [XLEN-1:0]    imm_c_o,
  output logic               illegal_c_o
);

  // Every format is first built as a 32-bit sign-extended value, then widened.
  logic [31:0] raw32;
  logic        s;

  assign s = instr_i[31];

  always_comb begin
    raw32       = '0;
    illegal_c_o = 1'b0;
    case (sel_i)
      I_TYPE:  raw32 = {{20{s}}, instr_i[31:20]};
      S_TYPE:  raw32 = {{20{s}}, instr_i[31:25], instr_i[11:7]};
      B_TYPE:  raw32 = {{19{s}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      U_TYPE:  raw32 = {instr_i[31:12], 12'b0};
      J_TYPE:  raw32 = {{11{s}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      // Bit 31 is zero, so the widening below leaves it zero-extended.
      Z_TYPE:  raw32 = {27'b0, instr_i[19:15]};
`ifdef IMM_RVC_EN
      CI_TYPE: raw32 = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
      CB_TYPE: raw32 = {{23{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2],
                        instr_i[11:10], instr_i[4:3], 1'b0};
      CJ_TYPE: raw32 = {{20{instr_i[12]}}, instr_i[12], instr_i[8], instr_i[10:9],
                        instr_i[6], instr_i[7], instr_i[2], instr_i[11],
                        instr_i[5:3], 1'b0};
`endif
      default: begin
        raw32       = '0;
        illegal_c_o = 1'b1;
      end
    endcase
  end

  assign imm_c_o = XLEN'($signed(raw32));

`ifndef IMM_RVC_EN
  // Opcode bits only feed the compressed formats.
  logic unused_opcode;
  assign unused_opcode = ^instr_i[6:0];
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry elastic buffer.
// Ports: clk, rst_n (sync, active-low), flush
//        in_valid/in_ready, in_instr, in_sel, in_pc   upstream side
//        out_valid/out_ready, out_imm, out_target, out_illegal   downstream side
// Macro IMM_RVC_EN enables the compressed immediate formats in imm_decode.
module imm_gen_pipe
  import rv32_pipeline_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  IMMEDIATE_SELECT    in_sel,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_target,
  output logic               out_illegal
);

  // Buffered decode result; fields are XLEN-wide so the struct is local.
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;
  } imm_entry_t;

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  imm_entry_t      dec_entry;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i     (in_instr),
    .sel_i       (in_sel),
    .imm_c_o     (dec_imm),
    .illegal_c_o (dec_illegal)
  );

  assign dec_entry = '{imm: dec_imm, target: in_pc + dec_imm, illegal: dec_illegal};

  buf_state_e state_q, state_d;
  imm_entry_t head_q, head_d;
  imm_entry_t skid_q, skid_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BUF_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: head is always the oldest entry; skid only fills when head is held.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push) begin
            head_d  = dec_entry;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            head_d = dec_entry;
          end else if (push) begin
            skid_d  = dec_entry;
            state_d = BUF_TWO;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          // in_ready is low here, so no push can coincide with the pop.
          if (pop) begin
            head_d  = skid_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != BUF_TWO);
    out_valid_d = (state_d != BUF_EMPTY);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = head_q.imm;
  assign out_target  = head_q.target;
  assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe at XLEN=32 and XLEN=64.
module tb_imm_gen_pipe;
  import rv32_pipeline_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, flush;
  logic            in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]     in_instr, in_pc, out_imm, out_target;
  IMMEDIATE_SELECT in_sel;

  logic            in_valid64, in_ready64, out_valid64, out_ready64, out_illegal64;
  logic [31:0]     in_instr64;
  logic [63:0]     in_pc64, out_imm64, out_target64;
  IMMEDIATE_SELECT in_sel64;

  int checks = 0;
  int failures = 0;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_sel(in_sel), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64),
    .in_sel(in_sel64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
    .out_target(out_target64), .out_illegal(out_illegal64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input IMMEDIATE_SELECT sel,
                       input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_sel   = sel;
    in_pc    = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    offer(32'h0, I_TYPE, 32'h0); in_valid = 1'b0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; in_instr64 = '0; in_sel64 = I_TYPE; in_pc64 = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_imm !== 32'h0) begin failures++; $display("FAIL reset_out_imm got=%h exp=0", out_imm); end
    checks++; if (out_target !== 32'h0) begin failures++; $display("FAIL reset_out_target got=%h exp=0", out_target); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_out_illegal got=%b exp=0", out_illegal); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (in_ready64 !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready64 got=%b exp=1", in_ready64); end
  endtask

  task automatic test_formats32();
    logic [31:0]     instrs [9];
    IMMEDIATE_SELECT sels   [9];
    logic [31:0]     pcs    [9];
    logic [31:0]     eimm   [9];
    logic [31:0]     etgt   [9];
    logic            eill   [9];
    instrs = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h800000B7, 32'h0080006F,
               32'h800F8073, 32'h00800093, 32'hFFF00093, 32'h12345037};
    sels   = '{I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, Z_TYPE, I_TYPE,
               IMMEDIATE_SELECT'(4'hC), U_TYPE};
    pcs    = '{32'h100, 32'h40, 32'h200, 32'h0, 32'h200, 32'h10, 32'hFFFFFFFC,
               32'h300, 32'h10};
    eimm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h80000000, 32'h8,
               32'h1F, 32'h8, 32'h0, 32'h12345000};
    etgt   = '{32'hFF, 32'h3C, 32'h1FC, 32'h80000000, 32'h208,
               32'h2F, 32'h4, 32'h300, 32'h12345010};
    eill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      offer(instrs[i], sels[i], pcs[i]);
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fmt%0d_valid got=%b exp=1", i, out_valid); end
      checks++; if (out_imm !== eimm[i]) begin failures++; $display("FAIL fmt%0d_imm got=%h exp=%h", i, out_imm, eimm[i]); end
      checks++; if (out_target !== etgt[i]) begin failures++; $display("FAIL fmt%0d_target got=%h exp=%h", i, out_target, etgt[i]); end
      checks++; if (out_illegal !== eill[i]) begin failures++; $display("FAIL fmt%0d_illegal got=%b exp=%b", i, out_illegal, eill[i]); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fmt%0d_drain got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] instrs [3];
    IMMEDIATE_SELECT sels [3];
    logic [63:0] pcs [3];
    logic [63:0] eimm [3];
    logic [63:0] etgt [3];
    instrs = '{32'h800000B7, 32'h800F8073, 32'hFFF00093};
    sels   = '{U_TYPE, Z_TYPE, I_TYPE};
    pcs    = '{64'h1000, 64'h0, 64'h20};
    eimm   = '{64'hFFFFFFFF_80000000, 64'h1F, 64'hFFFFFFFF_FFFFFFFF};
    etgt   = '{64'hFFFFFFFF_80001000, 64'h1F, 64'h1F};
    out_ready64 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid64 = 1'b1; in_instr64 = instrs[i]; in_sel64 = sels[i]; in_pc64 = pcs[i];
      tick();
      in_valid64 = 1'b0;
      checks++; if (out_valid64 !== 1'b1) begin failures++; $display("FAIL x64_%0d_valid got=%b exp=1", i, out_valid64); end
      checks++; if (out_imm64 !== eimm[i]) begin failures++; $display("FAIL x64_%0d_imm got=%h exp=%h", i, out_imm64, eimm[i]); end
      checks++; if (out_target64 !== etgt[i]) begin failures++; $display("FAIL x64_%0d_target got=%h exp=%h", i, out_target64, etgt[i]); end
      checks++; if (out_illegal64 !== 1'b0) begin failures++; $display("FAIL x64_%0d_illegal got=%b exp=0", i, out_illegal64); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got [$];
    logic acc;
    out_ready = 1'b0;
    offer(32'h00100093, I_TYPE, 32'h0);
    tick();
    offer(32'h00200093, I_TYPE, 32'h0);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_imm !== 32'h1) begin failures++; $display("FAIL bp_head got=%h exp=1", out_imm); end
    offer(32'h00300093, I_TYPE, 32'h0);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_held_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_imm !== 32'h1) begin failures++; $display("FAIL bp_stable got=%b/%h exp=1/1", out_valid, out_imm); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) got.push_back(out_imm);
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      failures++; $display("FAIL bp_count got=%0d exp=3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== 32'(k + 1)) begin failures++; $display("FAIL bp_order%0d got=%h exp=%h", k, got[k], 32'(k + 1)); end
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(32'h00400093, I_TYPE, 32'h0);
    tick();
    offer(32'h00500093, I_TYPE, 32'h0);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_full got=%b exp=0", in_ready); end
    flush = 1'b1; out_ready = 1'b1;
    offer(32'h07700093, I_TYPE, 32'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush2_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush2_in_ready got=%b exp=1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush2_ghost%0d got=%b imm=%h exp=0", k, out_valid, out_imm); end
    end
    // One buffered entry plus an acceptable same-cycle offer: both must vanish.
    out_ready = 1'b0;
    offer(32'h00600093, I_TYPE, 32'h0);
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush1_pre_valid got=%b exp=1", out_valid); end
    flush = 1'b1;
    offer(32'h00700093, I_TYPE, 32'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush1_out_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush1_ghost got=%b imm=%h exp=0", out_valid, out_imm); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      offer({12'(k), 20'h00093}, I_TYPE, 32'h1000);
      tick();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d_in_ready got=%b exp=1", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_imm !== 32'(k)) begin failures++; $display("FAIL b2b%0d_out got=%b/%h exp=1/%h", k, out_valid, out_imm, 32'(k)); end
      checks++; if (out_target !== 32'h1000 + 32'(k)) begin failures++; $display("FAIL b2b%0d_target got=%h exp=%h", k, out_target, 32'h1000 + 32'(k)); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    offer(32'hFFF00093, IMMEDIATE_SELECT'(4'hF), 32'h55);
    tick();
    in_valid = 1'b0;
    checks++; if (out_illegal !== 1'b1 || out_target !== 32'h55) begin failures++; $display("FAIL mid_pre got=%b/%h exp=1/55", out_illegal, out_target); end
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_imm !== 32'h0 || out_target !== 32'h0) begin failures++; $display("FAIL mid_data got=%h/%h exp=0/0", out_imm, out_target); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL mid_illegal got=%b exp=0", out_illegal); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_release got=%b/%b exp=1/0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_formats32();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
